ex_muldiv: RTL and testbench



---
 rtl/ex_muldiv_pkg.sv | 37 +++
 rtl/ex_muldiv_sign_fix.sv | 28 ++
 rtl/ex_muldiv.sv | 162 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared constants, opcode map and state encoding for the iterative M-extension unit.
// The M opcodes are contiguous so decode is a simple range check.
package ex_muldiv_pkg;

    localparam int DW    = 32;
    localparam int OPW   = 5;
    localparam int CNT_W = 5;

    localparam logic [OPW-1:0] ALU_MUL    = 5'd10;
    localparam logic [OPW-1:0] ALU_MULH   = 5'd11;
    localparam logic [OPW-1:0] ALU_MULHSU = 5'd12;
    localparam logic [OPW-1:0] ALU_MULHU  = 5'd13;
    localparam logic [OPW-1:0] ALU_DIV    = 5'd14;
    localparam logic [OPW-1:0] ALU_DIVU   = 5'd15;
    localparam logic [OPW-1:0] ALU_REM    = 5'd16;
    localparam logic [OPW-1:0] ALU_REMU   = 5'd17;

    localparam logic [DW-1:0] MD_DIVZERO_Q = 32'hFFFF_FFFF;
    localparam logic [DW-1:0] MD_INT_MIN   = 32'h8000_0000;

    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_CALC = 3'd1,
        MD_FIX  = 3'd2,
        MD_FAST = 3'd3,
        MD_DONE = 3'd4
    } md_state_e;

    function automatic logic is_mop(input logic [OPW-1:0] op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

    function automatic logic is_div(input logic [OPW-1:0] op);
        return (op >= ALU_DIV) && (op <= ALU_REMU);
    endfunction

endpackage

// File: rtl/ex_muldiv_sign_fix.sv
// Turns the magnitude-domain engine result into the signed RV32 result and
// selects the half (product low/high, quotient, remainder) the opcode asks for.
module ex_muldiv_sign_fix
    import ex_muldiv_pkg::*;
(
    input  logic [OPW-1:0] op,
    input  logic [DW-1:0]  hi,
    input  logic [DW-1:0]  lo,
    input  logic           neg_a,
    input  logic           neg_b,
    output logic [DW-1:0]  result
);

    logic [2*DW-1:0] prod;

    always_comb begin
        prod = (neg_a ^ neg_b) ? -{hi, lo} : {hi, lo};
        case (op)
            ALU_MUL:                          result = prod[DW-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:  result = prod[2*DW-1:DW];
            ALU_DIV, ALU_DIVU:                result = (neg_a ^ neg_b) ? -lo : lo;
            // Remainder follows the dividend's sign.
            ALU_REM, ALU_REMU:                result = neg_a ? -hi : hi;
            default:                          result = '0;
        endcase
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32 M unit: 1-bit/cycle shift-add multiply and restoring divide on
// operand magnitudes, with special cases resolved at accept. Stalls the pipe while busy.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] md_op,
    input  logic [DW-1:0]  md_s1,
    input  logic [DW-1:0]  md_s2,
    input  logic           md_flush,
    output logic           md_stall,
    output logic           md_valid,
    output logic [DW-1:0]  md_result,
    output logic           md_busy,
    output logic [2:0]     md_dbg_state
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [DW-1:0]    b_q, b_d, hi_q, hi_d, lo_q, lo_d, res_q, res_d, result_q, result_d;
    logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic             valid_q, valid_d, busy_q, busy_d;

    logic             req, signed_a, signed_b, in_neg_a, in_neg_b, div_ge;
    logic [DW-1:0]    mag_a, mag_b, fix_result;
    logic [DW:0]      mul_sum, div_shift;

    assign req      = is_mop(md_op) && !md_flush;
    assign signed_a = md_op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    assign signed_b = md_op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
    assign in_neg_a = signed_a && md_s1[DW-1];
    assign in_neg_b = signed_b && md_s2[DW-1];
    assign mag_a    = in_neg_a ? -md_s1 : md_s1;
    assign mag_b    = in_neg_b ? -md_s2 : md_s2;

    // One engine step: multiply adds into hi and shifts right; divide shifts
    // the dividend bit into the partial remainder and subtracts if it fits.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign div_shift = {hi_q, lo_q[DW-1]};
    assign div_ge    = div_shift >= {1'b0, b_q};

    ex_muldiv_sign_fix u_sign_fix (
        .op     (op_q),
        .hi     (hi_q),
        .lo     (lo_q),
        .neg_a  (neg_a_q),
        .neg_b  (neg_b_q),
        .result (fix_result)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        res_d    = res_q;
        valid_d  = 1'b0;
        result_d = '0;
        case (state_q)
            MD_IDLE: begin
                if (req) begin
                    op_d    = md_op;
                    neg_a_d = in_neg_a;
                    neg_b_d = in_neg_b;
                    b_d     = mag_b;
                    lo_d    = mag_a;
                    hi_d    = '0;
                    cnt_d   = CNT_W'(DW - 1);
                    if (is_div(md_op) && md_s2 == '0) begin
                        res_d   = (md_op inside {ALU_REM, ALU_REMU}) ? md_s1 : MD_DIVZERO_Q;
                        state_d = MD_FAST;
                    end else if ((md_op inside {ALU_DIV, ALU_REM}) &&
                                 md_s1 == MD_INT_MIN && md_s2 == '1) begin
                        res_d   = (md_op == ALU_REM) ? '0 : MD_INT_MIN;
                        state_d = MD_FAST;
                    end else begin
                        state_d = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                if (md_flush) begin
                    state_d = MD_IDLE;
                end else begin
                    if (is_div(op_q)) begin
                        hi_d = div_ge ? (div_shift[DW-1:0] - b_q) : div_shift[DW-1:0];
                        lo_d = {lo_q[DW-2:0], div_ge};
                    end else begin
                        hi_d = mul_sum[DW:1];
                        lo_d = {mul_sum[0], lo_q[DW-1:1]};
                    end
                    // Counter parks at zero on exit so it never starts a second pass.
                    cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
                    if (cnt_q == '0) state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                if (md_flush) begin
                    state_d = MD_IDLE;
                end else begin
                    res_d   = fix_result;
                    state_d = MD_DONE;
                end
            end
            MD_FAST: begin
                state_d = md_flush ? MD_IDLE : MD_DONE;
            end
            MD_DONE: begin
                valid_d  = 1'b1;
                result_d = res_q;
                state_d  = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
        busy_d = (state_d != MD_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            res_q    <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            res_q    <= res_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            busy_q   <= busy_d;
        end
    end

    // Stall is forced low while reset is asserted so every output reads idle.
    assign md_stall     = rst_n && ((state_q == MD_IDLE && req) ||
                                    (state_q inside {MD_CALC, MD_FIX, MD_FAST}));
    assign md_valid     = valid_q;
    assign md_result    = result_q;
    assign md_busy      = busy_q;
    assign md_dbg_state = state_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed cases plus randomized ops against
// an arithmetic reference model, with latency, stall, flush and reset checks.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [OPW-1:0] md_op;
    logic [31:0]    md_s1, md_s2;
    logic           md_flush;
    logic           md_stall, md_valid, md_busy;
    logic [31:0]    md_result;
    logic [2:0]     md_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ex_muldiv dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .md_op        (md_op),
        .md_s1        (md_s1),
        .md_s2        (md_s2),
        .md_flush     (md_flush),
        .md_stall     (md_stall),
        .md_valid     (md_valid),
        .md_result    (md_result),
        .md_busy      (md_busy),
        .md_dbg_state (md_dbg_state)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        int ia, ib, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = a;
        ib = b;
        p  = 0;
        q  = 0;
        case (op)
            ALU_MUL:    begin p = sa * sb; return p[31:0];  end
            ALU_MULH:   begin p = sa * sb; return p[63:32]; end
            ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
            ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
            ALU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = ia / ib;
                return q;
            end
            ALU_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = ia % ib;
                return q;
            end
            ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REMU: return (b == 0) ? a : a % b;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic bit is_fast_case(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < ALU_DIV || op > ALU_REMU) return 1'b0;
        if (b == 0) return 1'b1;
        return (op == ALU_DIV || op == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [4:0] rand_nop();
        logic [4:0] v;
        v = 5'($urandom_range(0, 23));
        if (v >= ALU_MUL) v = v + 5'd8;
        return v;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- driver: one full transaction ----------------
    // Called at #1 after an edge with the unit idle. Returns in the valid cycle
    // with md_op dropped to a non-M opcode.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input bit flush_done, input string name);
        int lat, seen_k, stall_bad, busy_bad, zero_bad;
        logic [31:0] got, exp_v;
        lat = is_fast_case(op, a, b) ? 2 : 34;
        seen_k = -1; stall_bad = 0; busy_bad = 0; zero_bad = 0;
        got = 'x;
        exp_q.push_back(ref_md(op, a, b));
        md_op = op; md_s1 = a; md_s2 = b; md_flush = 1'b0;
        #1;
        n_checks++;
        if (md_stall !== 1'b1) begin n_fail++; $display("FAIL %s accept_stall got %b want 1", name, md_stall); end
        for (int k = 0; k <= lat + 3 && seen_k < 0; k++) begin
            @(posedge clk); #1;
            if (md_valid === 1'b1) begin
                seen_k = k;
                got = md_result;
            end else begin
                if (md_result !== 32'h0) zero_bad++;
                if (k < lat && md_busy !== 1'b1) busy_bad++;
                if (!hold) md_op = rand_nop();
                md_s1 = $urandom;
                md_s2 = $urandom;
                md_flush = flush_done && (k == lat - 1);
                #1;
                if (k < lat && md_stall !== (k + 1 < lat)) stall_bad++;
            end
        end
        md_op = rand_nop();
        md_flush = 1'b0;
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (seen_k != lat) begin n_fail++; $display("FAIL %s latency got %0d want %0d", name, seen_k, lat); end
        n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL %s result got %h want %h", name, got, exp_v); end
        n_checks++;
        if (stall_bad != 0) begin n_fail++; $display("FAIL %s stall_profile bad_cycles %0d want 0", name, stall_bad); end
        n_checks++;
        if (busy_bad != 0) begin n_fail++; $display("FAIL %s busy_profile bad_cycles %0d want 0", name, busy_bad); end
        n_checks++;
        if (zero_bad != 0) begin n_fail++; $display("FAIL %s result_not_zero bad_cycles %0d want 0", name, zero_bad); end
        n_checks++;
        if (md_busy !== 1'b0 || md_stall !== 1'b0) begin
            n_fail++; $display("FAIL %s idle_after_done busy %b stall %b want 0 0", name, md_busy, md_stall);
        end
    endtask

    task automatic watch_no_pulse(input int cycles, input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (md_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL %s spurious_valid got %0d want 0", name, bad); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; md_op = ALU_MUL; md_s1 = $urandom; md_s2 = $urandom; md_flush = 1'b0;
        #1;
        n_checks++;
        if (md_valid !== 1'b0 || md_result !== 32'h0) begin
            n_fail++; $display("FAIL reset_outputs valid %b result %h want 0 0", md_valid, md_result);
        end
        n_checks++;
        if (md_busy !== 1'b0 || md_stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy_stall busy %b stall %b want 0 0", md_busy, md_stall);
        end
        n_checks++;
        if (md_dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", md_dbg_state); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        md_op = rand_nop();
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (md_busy !== 1'b0 || md_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release busy %b valid %b want 0 0", md_busy, md_valid);
        end
    endtask

    task automatic test_arith();
        run_op(ALU_MUL,    32'd7,          32'hFFFF_FFFD, 1'b0, 1'b0, "mul_neg3");
        run_op(ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 1'b0, "mulhu_max");
        run_op(ALU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 1'b0, "mulhsu_m1");
        run_op(ALU_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 1'b0, "mulh_m1");
        run_op(ALU_DIV,    32'hFFFF_FFF9,  32'd2,         1'b0, 1'b0, "div_m7_2");
        run_op(ALU_REM,    32'hFFFF_FFF9,  32'd2,         1'b0, 1'b0, "rem_m7_2");
        run_op(ALU_DIVU,   32'd100,        32'd7,         1'b0, 1'b0, "divu_100_7");
        run_op(ALU_REMU,   32'd100,        32'd7,         1'b0, 1'b0, "remu_100_7");
    endtask

    task automatic test_fast();
        run_op(ALU_DIVU, 32'd1234,      32'd0,         1'b0, 1'b0, "divu_by0");
        run_op(ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "rem_ovf");
        run_op(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_ovf");
        run_op(ALU_REMU, 32'hDEAD_BEEF, 32'd0,         1'b0, 1'b0, "remu_by0");
    endtask

    task automatic test_flush_abort();
        md_op = ALU_DIV; md_s1 = 32'd1000; md_s2 = 32'd3; md_flush = 1'b0;
        @(posedge clk); #1;
        md_op = rand_nop();
        repeat (10) begin @(posedge clk); #1; end
        md_flush = 1'b1;
        @(posedge clk); #1;
        md_flush = 1'b0;
        n_checks++;
        if (md_busy !== 1'b0) begin n_fail++; $display("FAIL flush_abort_busy got %b want 0", md_busy); end
        watch_no_pulse(40, "flush_abort");
        run_op(ALU_MUL, 32'd12345, 32'd678, 1'b0, 1'b0, "mul_after_flush");
    endtask

    task automatic test_flush_idle();
        md_op = ALU_MUL; md_s1 = 32'd3; md_s2 = 32'd4; md_flush = 1'b1;
        #1;
        n_checks++;
        if (md_stall !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall got %b want 0", md_stall); end
        @(posedge clk); #1;
        n_checks++;
        if (md_busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle_accept busy %b want 0", md_busy); end
        md_flush = 1'b0; md_op = rand_nop();
        run_op(ALU_DIV, 32'hFFFF_FF00, 32'd5, 1'b0, 1'b1, "div_flush_in_done");
    endtask

    task automatic test_reset_mid();
        md_op = ALU_MUL; md_s1 = 32'd99; md_s2 = 32'd77; md_flush = 1'b0;
        repeat (21) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (md_valid !== 1'b0 || md_result !== 32'h0 || md_busy !== 1'b0 || md_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs valid %b result %h busy %b stall %b want all 0",
                     md_valid, md_result, md_busy, md_stall);
        end
        @(posedge clk);
        @(negedge clk);
        md_op = rand_nop();
        rst_n = 1'b1;
        watch_no_pulse(40, "reset_mid");
    endtask

    task automatic test_back_to_back();
        run_op(ALU_MUL, 32'd6, 32'd9, 1'b1, 1'b0, "mul_hold");
        run_op(ALU_DIV, 32'd81, 32'hFFFF_FFF7, 1'b0, 1'b0, "div_after_done");
        run_op(ALU_REMU, 32'd17, 32'd0, 1'b1, 1'b0, "remu0_hold");
    endtask

    task automatic test_random();
        logic [4:0] op;
        for (int i = 0; i < 28; i++) begin
            op = ALU_MUL + 5'($urandom_range(0, 7));
            run_op(op, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0), "rand");
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                n_checks++;
                if (md_valid !== 1'b0) begin n_fail++; $display("FAIL rand_gap_valid got %b want 0", md_valid); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_fast();
        test_flush_abort();
        test_flush_idle();
        test_reset_mid();
        test_back_to_back();
        test_random();
        watch_no_pulse(3, "final_idle");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
